// File: rtl/tile_scan_driver.sv
// Snapshots twelve 160-bit tiles each frame and scans them onto a 32x60 1/16-mux LED panel.
// Optional macro SCAN_BRIGHT_EN adds bright[1:0], which trims oe_n on-time within each DWELL.
module tile_scan_driver #(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef SCAN_BRIGHT_EN
  input  logic [1:0]    bright,
`endif
  input  logic [1919:0] tiles_in,
  output logic          sclk,
  output logic          d_up,
  output logic          d_dn,
  output logic          lat,
  output logic          oe_n,
  output logic [3:0]    addr,
  output logic          frame_done
);

  localparam int CW = 16;
  localparam logic [CW-1:0] HALF     = CW'(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL - 1);

  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_SHIFT, S_LATCH, S_DWELL} state_t;

  state_t          state, state_n;
  logic [3:0]      r, r_n, addr_n;
  logic [CW-1:0]   cnt, cnt_n, on_len;
  logic [2:0]      col, col_n;
  logic [3:0]      x, x_n;
  logic [1919:0]   snapshot, snap_n;
  logic            d_up_n, d_dn_n;

  // Tile k, pixel row rr, pixel x: MSB of the tile is row 0, x 0.
  function automatic logic pix(input logic [1919:0] s, input int k, input int rr, input int xx);
    logic [10:0] idx;
    idx = 11'(k * 160 + 159 - rr * 10 - xx);
    return s[idx];
  endfunction

  always_comb begin
    state_n = state;
    r_n     = r;
    cnt_n   = cnt;
    col_n   = col;
    x_n     = x;
    snap_n  = snapshot;
    addr_n  = addr;
    case (state)
      S_IDLE: begin
        addr_n = 4'd0;
        if (en) state_n = S_SNAP;
      end
      S_SNAP: begin
        snap_n  = tiles_in;
        cnt_n   = '0;
        col_n   = 3'd0;
        x_n     = 4'd0;
        state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (x == 4'd9) begin
            x_n = 4'd0;
            if (col == 3'd5) state_n = S_LATCH;
            else             col_n   = col + 3'd1;
          end else begin
            x_n = x + 4'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_LATCH: begin
        addr_n  = r;
        cnt_n   = '0;
        state_n = S_DWELL;
      end
      S_DWELL: begin
        if (cnt == DW_LAST) begin
          cnt_n = '0;
          col_n = 3'd0;
          x_n   = 4'd0;
          if (r == 4'd15) begin
            r_n     = 4'd0;
            state_n = S_SNAP;
          end else begin
            r_n     = r + 4'd1;
            state_n = S_SHIFT;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (!en) begin
      state_n = S_IDLE;
      r_n     = 4'd0;
      cnt_n   = '0;
      col_n   = 3'd0;
      x_n     = 4'd0;
      addr_n  = 4'd0;
    end
    // Data is recomputed from next-cycle coordinates, so it only moves when a new bit begins.
    d_up_n = d_up;
    d_dn_n = d_dn;
    if (state_n == S_SHIFT) begin
      d_up_n = pix(snap_n, int'(col_n),     int'(r_n), int'(x_n));
      d_dn_n = pix(snap_n, int'(col_n) + 6, int'(r_n), int'(x_n));
    end else if (state_n == S_IDLE) begin
      d_up_n = 1'b0;
      d_dn_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      r        <= 4'd0;
      cnt      <= '0;
      col      <= 3'd0;
      x        <= 4'd0;
      snapshot <= '0;
      addr     <= 4'd0;
      d_up     <= 1'b0;
      d_dn     <= 1'b0;
    end else begin
      state    <= state_n;
      r        <= r_n;
      cnt      <= cnt_n;
      col      <= col_n;
      x        <= x_n;
      snapshot <= snap_n;
      addr     <= addr_n;
      d_up     <= d_up_n;
      d_dn     <= d_dn_n;
    end
  end

`ifdef SCAN_BRIGHT_EN
  logic [1:0] bright_q;

  always_ff @(posedge clk) begin
    if (rst)                 bright_q <= 2'd0;
    else if (state == S_LATCH) bright_q <= bright;
  end

  always_comb begin
    case (bright_q)
      2'd0:    on_len = CW'(DWELL / 4);
      2'd1:    on_len = CW'(2 * DWELL / 4);
      2'd2:    on_len = CW'(3 * DWELL / 4);
      default: on_len = CW'(DWELL);
    endcase
  end
`else
  assign on_len = CW'(DWELL);
`endif

  assign sclk       = (state == S_SHIFT) && (cnt >= HALF);
  assign lat        = (state == S_LATCH);
  assign oe_n       = !((state == S_DWELL) && (cnt < on_len));
  assign frame_done = en && (state == S_DWELL) && (cnt == DW_LAST) && (r == 4'd15);

endmodule

// File: tb/tb_tile_scan_driver.sv
// Bench for tile_scan_driver at default parameters; single-pixel vectors plus snapshot and enable-drop sequences.
module tb_tile_scan_driver;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1919:0] tiles_in;
  logic          sclk, d_up, d_dn, lat, oe_n, frame_done;
  logic [3:0]    addr;
`ifdef SCAN_BRIGHT_EN
  logic [1:0]    bright;
`endif

  tile_scan_driver dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
`ifdef SCAN_BRIGHT_EN
    .bright     (bright),
`endif
    .tiles_in   (tiles_in),
    .sclk       (sclk),
    .d_up       (d_up),
    .d_dn       (d_dn),
    .lat        (lat),
    .oe_n       (oe_n),
    .addr       (addr),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int n_cyc, done, bitpos, up_cnt, dn_cnt, up_pos, dn_pos;
  int first_lat, lat_cnt, oe_low, addr_bad, oe_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Observe one frame from the cycle after en rises (or after the previous frame_done).
  task automatic run_frame(input int change_at, input logic [1919:0] new_tiles);
    logic prev;
    prev = 1'b0;
    n_cyc = 0; done = 0; bitpos = 0; up_cnt = 0; dn_cnt = 0; up_pos = -1; dn_pos = -1;
    first_lat = -1; lat_cnt = 0; oe_low = 0; addr_bad = 0; oe_bad = 0;
    for (int c = 1; c <= 9000 && done == 0; c++) begin
      @(negedge clk);
      n_cyc = c;
      if (sclk && !prev) begin
        if (d_up) begin up_cnt++; up_pos = bitpos; end
        if (d_dn) begin dn_cnt++; dn_pos = bitpos; end
        bitpos++;
      end
      prev = sclk;
      if ((sclk || lat) && !oe_n) oe_bad++;
      if (lat) begin
        lat_cnt++;
        if (first_lat < 0) first_lat = c;
      end
      if (!oe_n) begin
        oe_low++;
        if (addr != 4'(lat_cnt - 1)) addr_bad++;
      end
      if (frame_done) done = 1;
      if (c == change_at) tiles_in = new_tiles;
    end
    check("frame_done_seen", done, 1);
  endtask

  function automatic int exp_oe_low();
`ifdef SCAN_BRIGHT_EN
    return (int'(bright) + 1) * 64 * 16;
`else
    return 4096;
`endif
  endfunction

  typedef struct {
    int tile_bit;
    int exp_up_cnt;
    int exp_up_pos;
    int exp_dn_cnt;
    int exp_dn_pos;
  } vec_t;

  vec_t vecs[4];
  logic [1919:0] t;

  initial begin
    // tile_bit = k*160 + 159 - (row*10 + x); position = row*60 + col*10 + x
    vecs[0] = '{159,  1, 0,   0, -1};   // tile 0, row 0, x 0
    vecs[1] = '{1760, 0, -1,  1, 959};  // tile 11, row 15, x 9
    vecs[2] = '{925,  1, 234, 0, -1};   // tile 5, row 3, x 4
    vecs[3] = '{1049, 0, -1,  1, 420};  // tile 6, row 7, x 0

    tiles_in = '0;
`ifdef SCAN_BRIGHT_EN
    bright = 2'd3;
`endif
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sclk", sclk, 0);
    check("rst_d_up", d_up, 0);
    check("rst_d_dn", d_dn, 0);
    check("rst_lat", lat, 0);
    check("rst_oe_n", oe_n, 1);
    check("rst_addr", addr, 0);
    check("rst_frame_done", frame_done, 0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      t = '0;
      t[vecs[i].tile_bit] = 1'b1;
      tiles_in = t;
      en = 1'b1;
      run_frame(-1, '0);
      check($sformatf("v%0d_period", i), n_cyc, 7953);
      check($sformatf("v%0d_first_lat", i), first_lat, 242);
      check($sformatf("v%0d_bits", i), bitpos, 960);
      check($sformatf("v%0d_up_cnt", i), up_cnt, vecs[i].exp_up_cnt);
      check($sformatf("v%0d_up_pos", i), up_pos, vecs[i].exp_up_pos);
      check($sformatf("v%0d_dn_cnt", i), dn_cnt, vecs[i].exp_dn_cnt);
      check($sformatf("v%0d_dn_pos", i), dn_pos, vecs[i].exp_dn_pos);
      check($sformatf("v%0d_lat_cnt", i), lat_cnt, 16);
      check($sformatf("v%0d_oe_low", i), oe_low, exp_oe_low());
      check($sformatf("v%0d_addr_bad", i), addr_bad, 0);
      check($sformatf("v%0d_oe_during_shift", i), oe_bad, 0);
    end

    // Mid-frame tile change: old pixel (x 0) for this frame, new pixel (x 1) next frame.
    do_reset();
    t = '0;
    t[159] = 1'b1;
    tiles_in = t;
    en = 1'b1;
    t = '0;
    t[158] = 1'b1;
    run_frame(3, t);
    check("snap_old_up_cnt", up_cnt, 1);
    check("snap_old_up_pos", up_pos, 0);
    run_frame(-1, '0);
    check("snap_new_period", n_cyc, 7953);
    check("snap_new_up_cnt", up_cnt, 1);
    check("snap_new_up_pos", up_pos, 1);
    check("snap_new_addr_bad", addr_bad, 0);

    // Drop en at SHIFT cycle 100 with all pixels lit, then restart.
    do_reset();
    tiles_in = '1;
    en = 1'b1;
    repeat (102) @(negedge clk);
    check("drop_pre_d_up", d_up, 1);
    check("drop_pre_lat", lat, 0);
    en = 1'b0;
    @(negedge clk);
    check("drop_sclk", sclk, 0);
    check("drop_lat", lat, 0);
    check("drop_oe_n", oe_n, 1);
    check("drop_d_up", d_up, 0);
    check("drop_d_dn", d_dn, 0);
    repeat (3) @(negedge clk);
    check("drop_idle_oe_n", oe_n, 1);
    check("drop_idle_frame_done", frame_done, 0);
    en = 1'b1;
    run_frame(-1, '0);
    check("restart_period", n_cyc, 7953);
    check("restart_first_lat", first_lat, 242);
    check("restart_up_cnt", up_cnt, 960);
    check("restart_dn_cnt", dn_cnt, 960);
    check("restart_addr_bad", addr_bad, 0);

`ifdef SCAN_BRIGHT_EN
    bright = 2'd0;
    run_frame(-1, '0);
    check("bright0_period", n_cyc, 7953);
    check("bright0_oe_low", oe_low, 1024);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
